// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter: round-robin selection among EU_N result channels
// into a single registered CDB slot with consumer backpressure and flush.
module cdb_rr_arbiter #(
  parameter int unsigned EU_N        = 8,
  parameter int unsigned ROB_IDX_LEN = 3,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned EXCEPT_LEN  = 5,
  localparam int unsigned W          = ROB_IDX_LEN + XLEN + 1 + EXCEPT_LEN,
  localparam int unsigned SRC_W      = (EU_N > 1) ? $clog2(EU_N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [EU_N-1:0]     eu_valid_i,
  output logic [EU_N-1:0]     eu_ready_o,
  input  logic [EU_N*W-1:0]   eu_data_i,
  input  logic                rob_ready_i,
  output logic                cdb_valid_o,
  output logic [W-1:0]        cdb_data_o,
  output logic [SRC_W-1:0]    cdb_src_o
);

  logic [SRC_W-1:0] last_gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] srch_idx;
  logic [EU_N-1:0]  gnt_vec;
  logic             gnt_found;
  logic             grant_en;
  logic [W-1:0]     payload [EU_N];

  // Unpack the flat channel bus into per-channel payloads.
  for (genvar k = 0; k < EU_N; k++) begin : g_unpack
    assign payload[k] = eu_data_i[k*W +: W];
  end

  // A grant may be issued only when the slot is empty or being drained this cycle.
  assign grant_en = (!cdb_valid_o || rob_ready_i) && !flush_i && !rst_i;

  // Rotating priority search starting one past the last winner, wrapping modulo EU_N.
  always_comb begin
    gnt_vec   = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    srch_idx  = '0;
    for (int unsigned i = 1; i <= EU_N; i++) begin
      srch_idx = SRC_W'((32'(last_gnt) + i) % EU_N);
      if (!gnt_found && eu_valid_i[srch_idx]) begin
        gnt_found         = 1'b1;
        gnt_idx           = srch_idx;
        gnt_vec[srch_idx] = 1'b1;
      end
    end
  end

  assign eu_ready_o = grant_en ? gnt_vec : '0;

  // CDB slot and round-robin pointer; flush empties the slot and freezes the pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdb_valid_o <= 1'b0;
      cdb_data_o  <= '0;
      cdb_src_o   <= '0;
      last_gnt    <= SRC_W'(EU_N - 1);
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
    end else if (grant_en && gnt_found) begin
      cdb_valid_o <= 1'b1;
      cdb_data_o  <= payload[gnt_idx];
      cdb_src_o   <= gnt_idx;
      last_gnt    <= gnt_idx;
    end else if (rob_ready_i) begin
      cdb_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: reset, contention, backpressure,
// sparse requests, flush, payload fields and the single-channel case.
module tb_cdb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 3 + 64 + 1 + 5;
  localparam int unsigned SW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [N-1:0]    eu_valid_i;
  logic [N-1:0]    eu_ready_o;
  logic [N*W-1:0]  eu_data_i;
  logic            rob_ready_i;
  logic            cdb_valid_o;
  logic [W-1:0]    cdb_data_o;
  logic [SW-1:0]   cdb_src_o;

  logic            v1;
  logic            r1;
  logic [W-1:0]    d1;
  logic            rr1;
  logic            cv1;
  logic [W-1:0]    cd1;
  logic            cs1;

  int vectors = 0;
  int errors  = 0;

  cdb_rr_arbiter #(.EU_N(N), .ROB_IDX_LEN(3), .XLEN(64), .EXCEPT_LEN(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_data_i(eu_data_i),
    .rob_ready_i(rob_ready_i), .cdb_valid_o(cdb_valid_o),
    .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
  );

  cdb_rr_arbiter #(.EU_N(1), .ROB_IDX_LEN(3), .XLEN(64), .EXCEPT_LEN(5)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(1'b0),
    .eu_valid_i(v1), .eu_ready_o(r1), .eu_data_i(d1),
    .rob_ready_i(rr1), .cdb_valid_o(cv1),
    .cdb_data_o(cd1), .cdb_src_o(cs1)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] mk(input logic [2:0] rob, input logic [63:0] val,
                                      input logic er, input logic [4:0] ec);
    return {rob, val, er, ec};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [SW-1:0] src, input logic [W-1:0] data);
    chk({tag, ".valid"}, 128'(cdb_valid_o), 128'(1'b1));
    chk({tag, ".src"},   128'(cdb_src_o),   128'(src));
    chk({tag, ".data"},  128'(cdb_data_o),  128'(data));
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    eu_valid_i  = '0;
    rob_ready_i = 1'b1;
    v1 = 1'b0; rr1 = 1'b1; d1 = mk(3'd7, 64'h55, 1'b0, 5'd1);
    for (int k = 0; k < N; k++) eu_data_i[k*W +: W] = mk(3'(k), 64'h100 + 64'(k), 1'b0, 5'd0);
    tick();
    tick();
    chk("rst.valid", 128'(cdb_valid_o), 128'(0));
    chk("rst.data",  128'(cdb_data_o),  128'(0));
    chk("rst.src",   128'(cdb_src_o),   128'(0));
    eu_valid_i = 4'b1111;
    #1;
    chk("rst.ready", 128'(eu_ready_o), 128'(0));

    // Full contention: 0,1,2,3,0,1
    rst_i = 1'b0;
    #1;
    chk("fc.ready0", 128'(eu_ready_o), 128'(4'b0001));
    tick(); slot("fc0", 2'd0, mk(3'd0, 64'h100, 1'b0, 5'd0));
    chk("fc.ready1", 128'(eu_ready_o), 128'(4'b0010));
    tick(); slot("fc1", 2'd1, mk(3'd1, 64'h101, 1'b0, 5'd0));
    tick(); slot("fc2", 2'd2, mk(3'd2, 64'h102, 1'b0, 5'd0));
    tick(); slot("fc3", 2'd3, mk(3'd3, 64'h103, 1'b0, 5'd0));
    chk("fc.wrap", 128'(eu_ready_o), 128'(4'b0001));
    tick(); slot("fc4", 2'd0, mk(3'd0, 64'h100, 1'b0, 5'd0));
    tick(); slot("fc5", 2'd1, mk(3'd1, 64'h101, 1'b0, 5'd0));

    // Backpressure for 3 cycles while slot holds 0x101
    rob_ready_i = 1'b0;
    #1;
    chk("bp.ready", 128'(eu_ready_o), 128'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      slot("bp.hold", 2'd1, mk(3'd1, 64'h101, 1'b0, 5'd0));
      chk("bp.ready_hold", 128'(eu_ready_o), 128'(0));
    end
    rob_ready_i = 1'b1;
    #1;
    chk("bp.release", 128'(eu_ready_o), 128'(4'b0100));
    tick(); slot("bp.next", 2'd2, mk(3'd2, 64'h102, 1'b0, 5'd0));

    // Sparse requests: bring pointer to 3, then 2 alone, then 1 alone
    eu_valid_i = 4'b1000;
    #1;
    chk("sp.ready3", 128'(eu_ready_o), 128'(4'b1000));
    tick(); slot("sp3", 2'd3, mk(3'd3, 64'h103, 1'b0, 5'd0));
    eu_valid_i = 4'b0100;
    #1;
    chk("sp.ready2", 128'(eu_ready_o), 128'(4'b0100));
    tick(); slot("sp2", 2'd2, mk(3'd2, 64'h102, 1'b0, 5'd0));
    eu_valid_i = 4'b0010;
    #1;
    chk("sp.ready1", 128'(eu_ready_o), 128'(4'b0010));
    tick(); slot("sp1", 2'd1, mk(3'd1, 64'h101, 1'b0, 5'd0));
    eu_valid_i = 4'b0000;
    #1;
    chk("sp.idle_ready", 128'(eu_ready_o), 128'(0));
    tick();
    chk("sp.drop", 128'(cdb_valid_o), 128'(0));

    // Flush with channels 0 and 3 requesting, slot valid
    eu_valid_i = 4'b1001;
    #1;
    chk("fl.pre_ready", 128'(eu_ready_o), 128'(4'b1000));
    tick(); slot("fl.pre", 2'd3, mk(3'd3, 64'h103, 1'b0, 5'd0));
    flush_i = 1'b1;
    #1;
    chk("fl.ready", 128'(eu_ready_o), 128'(0));
    tick();
    chk("fl.valid", 128'(cdb_valid_o), 128'(0));
    flush_i = 1'b0;
    #1;
    chk("fl.resume_ready", 128'(eu_ready_o), 128'(4'b0001));
    tick(); slot("fl.res0", 2'd0, mk(3'd0, 64'h100, 1'b0, 5'd0));
    chk("fl.resume_next", 128'(eu_ready_o), 128'(4'b1000));
    tick(); slot("fl.res3", 2'd3, mk(3'd3, 64'h103, 1'b0, 5'd0));

    // Payload field integrity through channel 1
    eu_data_i[1*W +: W] = mk(3'd5, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'h0d);
    eu_valid_i = 4'b0010;
    #1;
    chk("pl.ready", 128'(eu_ready_o), 128'(4'b0010));
    tick();
    slot("pl", 2'd1, mk(3'd5, 64'hDEAD_BEEF_0123_4567, 1'b1, 5'h0d));
    chk("pl.rob_idx", 128'(cdb_data_o[72:70]), 128'(3'd5));
    chk("pl.value",   128'(cdb_data_o[69:6]),  128'(64'hDEAD_BEEF_0123_4567));
    chk("pl.exc_r",   128'(cdb_data_o[5]),     128'(1'b1));
    chk("pl.exc_c",   128'(cdb_data_o[4:0]),   128'(5'h0d));

    // Asynchronous reset mid-cycle with all channels requesting
    eu_valid_i = 4'b1111;
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar.valid", 128'(cdb_valid_o), 128'(0));
    chk("ar.ready", 128'(eu_ready_o),  128'(0));
    chk("ar.src",   128'(cdb_src_o),   128'(0));
    tick();
    rst_i = 1'b0;
    #1;
    chk("ar.first_ready", 128'(eu_ready_o), 128'(4'b0001));
    tick(); slot("ar.first", 2'd0, mk(3'd0, 64'h100, 1'b0, 5'd0));
    eu_valid_i = 4'b0000;

    // Single-channel instance
    v1 = 1'b1;
    #1;
    chk("n1.ready", 128'(r1), 128'(1'b1));
    tick();
    chk("n1.valid", 128'(cv1), 128'(1'b1));
    chk("n1.src",   128'(cs1), 128'(1'b0));
    chk("n1.data",  128'(cd1), 128'(mk(3'd7, 64'h55, 1'b0, 5'd1)));
    rr1 = 1'b0;
    #1;
    chk("n1.bp_ready", 128'(r1), 128'(1'b0));
    tick();
    chk("n1.bp_valid", 128'(cv1), 128'(1'b1));
    v1 = 1'b0;
    rr1 = 1'b1;
    tick();
    chk("n1.drain", 128'(cv1), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Parametrised common-data-bus arbiter for the execution pipeline.
- Collects results from EU_N execution-unit channels over valid/ready handshakes and picks one per cycle using a rotating round-robin pointer.
- Broadcasts the winner through a single registered CDB slot towards the ROB and reservation stations.
- Generalises the fixed CDB payload to configurable channel count, ROB index width, data width and exception-code width; supports ROB backpressure and pipeline flush.

Parameters:
- EU_N, 8, number of requesting channels (>=1).
- ROB_IDX_LEN, 3, width of the ROB index field.
- XLEN, 64, result value width.
- EXCEPT_LEN, 5, exception code width.
- Derived W = ROB_IDX_LEN + XLEN + 1 + EXCEPT_LEN, the payload width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; drops the CDB slot.
- eu_valid_i  in  EU_N  channel k holds a result.
- eu_ready_o  out  EU_N  channel k result accepted this cycle (one-hot or zero).
- eu_data_i  in  EU_N*W  channel k payload at [k*W +: W]; field order MSB to LSB is {rob_idx, value, except_raised, except_code}.
- rob_ready_i  in  1  consumers accept the current CDB slot.
- cdb_valid_o  out  1  CDB slot valid.
- cdb_data_o  out  W  CDB payload, same field order.
- cdb_src_o  out  $clog2(EU_N) (min 1)  index of the channel that produced the slot.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - cdb_valid_o=0, cdb_data_o=0, cdb_src_o=0.
  - Pointer last_gnt=EU_N-1, so channel 0 has first priority.
  - eu_ready_o=0 while rst_i is high.
- Slot free condition: free = !cdb_valid_o || rob_ready_i.
- Grant, combinational:
  - Only when free && !flush_i.
  - Search order is last_gnt+1, last_gnt+2, ... wrapping modulo EU_N; the first channel with eu_valid_i=1 wins.
  - eu_ready_o is one-hot on the winner; all zeros if there is no requester, the slot is not free, or flush_i=1.
  - eu_ready_o must not depend on eu_data_i.
- Transfer: occurs on a clock edge where eu_valid_i[k] && eu_ready_o[k]. At that edge:
  - cdb_valid_o<=1.
  - cdb_data_o<=payload k.
  - cdb_src_o<=k.
  - last_gnt<=k.
- Latency: 1 cycle from the accepting edge to cdb_valid_o high.
- Throughput: one result per cycle while rob_ready_i=1.
- Consume without refill: if cdb_valid_o && rob_ready_i and no grant, then cdb_valid_o<=0. Data and src hold their last values (don't-care).
- Backpressure: cdb_valid_o && !rob_ready_i keeps data/src stable, eu_ready_o=0 and last_gnt unchanged.
- Flush: flush_i=1 at an edge forces cdb_valid_o<=0. No grant is issued in that cycle and last_gnt is unchanged. Requests are re-arbitrated in the cycle after flush_i deasserts.
- Channel contract: a channel holds valid and data stable until accepted. The arbiter accepts no duty to detect violations.
- Fairness: a continuously requesting channel is granted within EU_N grants.
- EU_N=1: the pointer is constant and the channel is granted whenever the slot is free.
- Pointer wrap: when last_gnt=EU_N-1 the search starts at 0.
- No combinational path from rob_ready_i to cdb_* outputs. The only combinational paths are rob_ready_i/eu_valid_i/flush_i to eu_ready_o.

Test Plan:
- Reset: assert rst_i mid-cycle with all valids high → cdb_valid_o=0, eu_ready_o=0 immediately; after release, first grant goes to channel 0.
- Full contention (EU_N=4, all valid, rob_ready_i=1, payload k value=0x100+k) → cdb_src_o sequence 0,1,2,3,0,1, each on consecutive cycles with matching value.
- Backpressure: slot holding value 0x101 with rob_ready_i=0 for 3 cycles → cdb_data_o constant and eu_ready_o=0; on release the next grant goes to channel 2 (pointer continues from 1).
- Sparse: last_gnt=3, only channel 2 valid → grant 2 the same cycle; next cycle only channel 1 valid → grant 1; cdb_valid_o drops one cycle after requests stop.
- Flush: flush_i pulsed while cdb_valid_o=1 and channels 0 and 3 are requesting → cdb_valid_o=0 next cycle, no eu_ready_o in the flush cycle, then channel order resumes from the unchanged pointer.
- Payload integrity: channel 1 sends rob_idx=5, except_raised=1, except_code=0x0d → cdb_data_o fields match bit-exactly and cdb_src_o=1.
